// File: rtl/dmem_responder.sv
// Memory-side end of the core's data-memory handshake: one outstanding request,
// byte-addressed little-endian 32-bit RAM, fixed programmable response latency.
package dmem_responder_pkg;
   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;
endpackage

module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int LATENCY_P = 2
) (
   input  logic              clk,
   input  logic              n_reset,
   input  mem_in_s           mem_i,
   input  logic [ADDR_W-1:0] addr_i,
   output mem_out_s          mem_o,
   output logic              busy_o,
   output logic              misalign_o
);

   localparam int         WORDS    = 1 << (ADDR_W - 2);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam bit         HAS_WAIT = (LATENCY_P > 0);
   localparam logic [3:0] CNT_LOAD = 4'((LATENCY_P > 0) ? (LATENCY_P - 1) : 0);

   function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                              input logic [7:0]  data,
                                              input logic [1:0]  lane);
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = data;
         2'd1:    res[15:8]  = data;
         2'd2:    res[23:16] = data;
         2'd3:    res[31:24] = data;
         default: res        = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      return {24'd0, b};
   endfunction

   logic [31:0]       ram_q [0:WORDS-1];
   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       resp_q, resp_d;
   logic              misalign_q, misalign_d;
   logic              accept_s;
   logic              ram_we_s;
   logic [ADDR_W-3:0] word_idx_s;
   logic [31:0]       ram_rd_s;
   logic [31:0]       wr_word_s;
   logic [31:0]       resp_word_s;

   // Request datapath: RAM read, write-word merge and response word selection.
   always_comb begin
      accept_s   = (state_q == ST_IDLE) & mem_i.valid & n_reset;
      word_idx_s = addr_i[ADDR_W-1:2];
      ram_rd_s   = ram_q[word_idx_s];
      ram_we_s   = accept_s & mem_i.wen;
      if (mem_i.byte_not_word) begin
         wr_word_s = merge_byte(ram_rd_s, mem_i.write_data[7:0], addr_i[1:0]);
      end else begin
         wr_word_s = mem_i.write_data;
      end
      if (mem_i.wen) begin
         resp_word_s = wr_word_s;
      end else if (mem_i.byte_not_word) begin
         resp_word_s = pick_byte(ram_rd_s, addr_i[1:0]);
      end else begin
         resp_word_s = ram_rd_s;
      end
   end

   // Handshake FSM next-state: accept in IDLE, count down in WAIT, hold in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      resp_d     = resp_q;
      misalign_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               resp_d     = resp_word_s;
               misalign_d = ~mem_i.byte_not_word & (addr_i[1:0] != 2'b00);
               if (HAS_WAIT) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (mem_i.yumi) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and response registers; a reset drops any in-flight response.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         resp_q     <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
         misalign_q <= misalign_d;
      end
   end

   // RAM is deliberately not reset so committed writes survive a reset.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[word_idx_s] <= wr_word_s;
      end
   end

   // Output decode from registered state; yumi is the combinational accept.
   always_comb begin
      mem_o.read_data = resp_q;
      mem_o.valid     = (state_q == ST_RESP);
      mem_o.yumi      = accept_s;
      busy_o          = (state_q != ST_IDLE);
      misalign_o      = misalign_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY_P=2, one with LATENCY_P=0.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   mem_in_s     mi0, mi1;
   mem_out_s    mo0, mo1;
   logic [11:0] a0, a1;
   logic        busy0, busy1, mis0, mis1;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sbq[$];
   logic [31:0] mdl[int];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(12), .LATENCY_P(2)) dut (
      .clk(clk), .n_reset(n_reset), .mem_i(mi0), .addr_i(a0),
      .mem_o(mo0), .busy_o(busy0), .misalign_o(mis0));

   dmem_responder #(.ADDR_W(12), .LATENCY_P(0)) dut0 (
      .clk(clk), .n_reset(n_reset), .mem_i(mi1), .addr_i(a1),
      .mem_o(mo1), .busy_o(busy1), .misalign_o(mis1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic mem_out_s out_of(input bit sel);
      return sel ? mo1 : mo0;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy1 : busy0;
   endfunction

   function automatic logic mis_of(input bit sel);
      return sel ? mis1 : mis0;
   endfunction

   task automatic drive(input bit sel, input mem_in_s m, input logic [11:0] a);
      if (sel) begin
         mi1 = m; a1 = a;
      end else begin
         mi0 = m; a0 = a;
      end
   endtask

   // One request through the handshake; expected word comes from the tb memory model.
   task automatic xact(input bit sel, input bit wen, input bit bnw, input logic [11:0] addr,
                       input logic [31:0] wd, input int exp_lat, input int hold,
                       input bit probe, input int exp_wait);
      mem_in_s     m;
      logic [31:0] cur, exp_w, held;
      logic        exp_mis;
      int          key, n;
      key = (sel ? 4096 : 0) + int'(addr[11:2]);
      cur = mdl.exists(key) ? mdl[key] : 32'd0;
      if (wen) begin
         exp_w = wd;
         if (bnw) begin
            exp_w = cur;
            exp_w[8*addr[1:0] +: 8] = wd[7:0];
         end
         mdl[key] = exp_w;
      end else if (bnw) begin
         exp_w = {24'd0, cur[8*addr[1:0] +: 8]};
      end else begin
         exp_w = cur;
      end
      exp_mis = !bnw && (addr[1:0] != 2'd0);
      sbq.push_back(exp_w);

      m = '{write_data: wd, valid: 1'b1, wen: wen, byte_not_word: bnw, yumi: 1'b0};
      drive(sel, m, addr);
      n = 0;
      @(negedge clk);
      while (out_of(sel).yumi !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_seen", {31'd0, out_of(sel).yumi}, 32'd1);
      if (exp_wait >= 0) chk("accept_wait", n, exp_wait);
      @(posedge clk); #1;
      m.valid = 1'b0;
      drive(sel, m, addr);
      chk("misalign", {31'd0, mis_of(sel)}, {31'd0, exp_mis});
      chk("busy", {31'd0, busy_of(sel)}, 32'd1);

      n = 1;
      while (out_of(sel).valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 2) chk("mis_pulse", {31'd0, mis_of(sel)}, 32'd0);
      end
      chk("latency", n, exp_lat);

      held = out_of(sel).read_data;
      if (probe) m.valid = 1'b1;
      drive(sel, m, addr);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, out_of(sel).valid}, 32'd1);
         chk("hold_data", out_of(sel).read_data, held);
         chk("hold_noyumi", {31'd0, out_of(sel).yumi}, 32'd0);
      end
      chk("rdata", held, sbq.pop_front());

      m.yumi = 1'b1;
      drive(sel, m, addr);
      #1;
      chk("resp_noyumi", {31'd0, out_of(sel).yumi}, 32'd0);
      @(posedge clk); #1;
      m.yumi = 1'b0;
      drive(sel, m, addr);
      chk("valid_drop", {31'd0, out_of(sel).valid}, 32'd0);
      chk("idle", {31'd0, busy_of(sel)}, 32'd0);
   endtask

   initial begin
      mem_in_s m;
      m = '{write_data: 32'd0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
      mi0 = m; mi1 = m; a0 = 12'd0; a1 = 12'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, mo0.valid}, 32'd0);
      chk("rst_rdata", mo0.read_data, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_mis", {31'd0, mis0}, 32'd0);
      chk("rst_yumi", {31'd0, mo0.yumi}, 32'd0);
      chk("rst_yumi0", {31'd0, mo1.yumi}, 32'd0);
      m.valid = 1'b0;
      mi0 = m; mi1 = m;
      n_reset = 1'b1;
      @(posedge clk); #1;

      xact(1'b0, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 12'h010, 32'h0,        3, 0, 1'b0, 0);
      xact(1'b0, 1'b1, 1'b0, 12'h010, 32'h11223344, 3, 0, 1'b0, 0);
      xact(1'b0, 1'b1, 1'b1, 12'h011, 32'h000000AA, 3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b1, 12'h011, 32'h0,        3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b1, 12'h013, 32'h0,        3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 12'h010, 32'h0,        3, 5, 1'b1, -1);
      xact(1'b0, 1'b1, 1'b0, 12'h014, 32'hCAFEF00D, 3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 12'h012, 32'h0,        3, 0, 1'b0, 0);
      xact(1'b0, 1'b1, 1'b0, 12'h017, 32'h01020304, 3, 0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 12'h014, 32'h0,        3, 0, 1'b0, 0);

      // Reset during WAIT of SW 0x55 @0x020; the write is already committed.
      m = '{write_data: 32'h55, valid: 1'b1, wen: 1'b1, byte_not_word: 1'b0, yumi: 1'b0};
      drive(1'b0, m, 12'h020);
      @(negedge clk);
      chk("rw_accept", {31'd0, mo0.yumi}, 32'd1);
      @(posedge clk); #1;
      mdl[int'(10'h008)] = 32'h55;
      m.valid = 1'b0;
      drive(1'b0, m, 12'h020);
      @(posedge clk); #1;
      chk("rw_busy", {31'd0, busy0}, 32'd1);
      n_reset = 1'b0;
      m.valid = 1'b1;
      drive(1'b0, m, 12'h020);
      #1;
      chk("rw_valid", {31'd0, mo0.valid}, 32'd0);
      chk("rw_busy0", {31'd0, busy0}, 32'd0);
      chk("rw_yumi", {31'd0, mo0.yumi}, 32'd0);
      chk("rw_rdata", mo0.read_data, 32'd0);
      @(posedge clk); #1;
      m.valid = 1'b0;
      drive(1'b0, m, 12'h020);
      n_reset = 1'b1;
      @(posedge clk); #1;
      xact(1'b0, 1'b0, 1'b0, 12'h020, 32'h0, 3, 0, 1'b0, 0);

      // Zero-latency instance, back-to-back requests.
      xact(1'b1, 1'b1, 1'b0, 12'h100, 32'h0BADF00D, 1, 0, 1'b1, 0);
      xact(1'b1, 1'b0, 1'b0, 12'h100, 32'h0,        1, 0, 1'b1, 0);
      xact(1'b1, 1'b0, 1'b1, 12'h103, 32'h0,        1, 2, 1'b1, 0);
      xact(1'b1, 1'b1, 1'b1, 12'h102, 32'h00000077, 1, 0, 1'b0, 0);
      xact(1'b1, 1'b0, 1'b0, 12'h100, 32'h0,        1, 0, 1'b0, 0);

      chk("sb_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
